// File: rtl/irq_controller.sv
// Four-source interrupt front end: edge detect, pending latch, mask, fixed priority (3 highest), in-service tracking.
// Define IRQ_NEST_EN to let a higher-priority source preempt a running handler; otherwise handlers never nest.
module irq_controller (
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic [3:0] in_req,
    input  logic       in_mask_we,
    input  logic [3:0] in_mask,
    input  logic       in_ack,
    input  logic       in_eret,
    output logic       out_irq,
    output logic [1:0] out_code,
    output logic [3:0] out_pending,
    output logic [3:0] out_in_service
);

    logic [3:0] req_q, req_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] in_service_q, in_service_d;

    logic [3:0] req_rise;
    logic [3:0] service_top;
    logic [3:0] allowed;
    logic [3:0] eligible;
    logic [3:0] ack_bit;
    logic [3:0] eret_bit;
    logic       irq;
    logic [1:0] code;

    always_comb begin
        req_d    = in_req;
        req_rise = in_req & ~req_q;

        service_top = 4'b0000;
        if (in_service_q[3])      service_top = 4'b1000;
        else if (in_service_q[2]) service_top = 4'b0100;
        else if (in_service_q[1]) service_top = 4'b0010;
        else if (in_service_q[0]) service_top = 4'b0001;

`ifdef IRQ_NEST_EN
        // Only sources strictly above the running handler may preempt it.
        allowed = 4'b1111;
        if (in_service_q[3])      allowed = 4'b0000;
        else if (in_service_q[2]) allowed = 4'b1000;
        else if (in_service_q[1]) allowed = 4'b1100;
        else if (in_service_q[0]) allowed = 4'b1110;
`else
        allowed = (in_service_q == 4'b0000) ? 4'b1111 : 4'b0000;
`endif

        eligible = pending_q & mask_q & allowed;
        irq      = |eligible;
        code     = 2'd0;
        if (eligible[3])      code = 2'd3;
        else if (eligible[2]) code = 2'd2;
        else if (eligible[1]) code = 2'd1;

        ack_bit  = (in_ack && irq) ? (4'b0001 << code) : 4'b0000;
        eret_bit = in_eret ? service_top : 4'b0000;

        // A new edge on the acknowledged source re-latches it (set wins).
        pending_d    = (pending_q & ~ack_bit) | req_rise;
        in_service_d = (in_service_q & ~eret_bit) | ack_bit;
        mask_d       = in_mask_we ? in_mask : mask_q;
    end

    always_ff @(posedge in_clk) begin
        req_q <= req_d;
        if (in_rst) begin
            pending_q    <= 4'b0000;
            mask_q       <= 4'b1111;
            in_service_q <= 4'b0000;
        end else begin
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            in_service_q <= in_service_d;
        end
    end

    assign out_irq        = irq;
    assign out_code       = code;
    assign out_pending    = pending_q;
    assign out_in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: stimulus queues hand-computed expectations, a negedge monitor checks them.
module tb_irq_controller;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       mask_we;
    logic [3:0] mask;
    logic       ack;
    logic       eret;
    logic       irq;
    logic [1:0] code;
    logic [3:0] pend;
    logic [3:0] isv;

    irq_controller dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .in_req         (req),
        .in_mask_we     (mask_we),
        .in_mask        (mask),
        .in_ack         (ack),
        .in_eret        (eret),
        .out_irq        (irq),
        .out_code       (code),
        .out_pending    (pend),
        .out_in_service (isv)
    );

    typedef struct {
        string      name;
        logic       irq;
        logic [1:0] code;
        logic [3:0] pend;
        logic [3:0] isv;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (irq !== e.irq || code !== e.code || pend !== e.pend || isv !== e.isv) begin
                n_fail++;
                $display("FAIL %s: got irq=%b code=%0d pend=%b isv=%b, want irq=%b code=%0d pend=%b isv=%b",
                         e.name, irq, code, pend, isv, e.irq, e.code, e.pend, e.isv);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        ack     = 1'b0;
        eret    = 1'b0;
        mask_we = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic e_irq, input logic [1:0] e_code,
                                input logic [3:0] e_pend, input logic [3:0] e_isv);
        exp_t e;
        e.name = name;
        e.irq  = e_irq;
        e.code = e_code;
        e.pend = e_pend;
        e.isv  = e_isv;
        exp_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0100; mask_we = 1'b0; mask = 4'b0000; ack = 1'b0; eret = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        expect_state("reset_held_level", 1'b0, 2'd0, 4'b0000, 4'b0000);

        req = 4'b0000; tick();
        req = 4'b0100; tick();
        expect_state("rise_src2", 1'b1, 2'd2, 4'b0100, 4'b0000);
        ack = 1'b1; tick();
        expect_state("ack_src2", 1'b0, 2'd0, 4'b0000, 4'b0100);
        eret = 1'b1; tick();
        expect_state("eret_src2", 1'b0, 2'd0, 4'b0000, 4'b0000);

        req = 4'b0000; tick();
        req = 4'b1010; tick();
        expect_state("dual_edge_prio", 1'b1, 2'd3, 4'b1010, 4'b0000);
        ack = 1'b1; tick();
        expect_state("ack_src3", 1'b0, 2'd0, 4'b0010, 4'b1000);
        eret = 1'b1; tick();
        expect_state("eret_src3", 1'b1, 2'd1, 4'b0010, 4'b0000);
        ack = 1'b1; tick();
        expect_state("ack_src1", 1'b0, 2'd0, 4'b0000, 4'b0010);
        eret = 1'b1; tick();
        expect_state("eret_src1", 1'b0, 2'd0, 4'b0000, 4'b0000);

        req = 4'b0000; mask_we = 1'b1; mask = 4'b1101; tick();
        req = 4'b0010; tick();
        expect_state("masked_pending", 1'b0, 2'd0, 4'b0010, 4'b0000);
        ack = 1'b1; tick();
        expect_state("ack_idle_ignored", 1'b0, 2'd0, 4'b0010, 4'b0000);
        mask_we = 1'b1; mask = 4'b1111; tick();
        expect_state("unmask", 1'b1, 2'd1, 4'b0010, 4'b0000);

        ack = 1'b1; tick();
        expect_state("nest_ack_src1", 1'b0, 2'd0, 4'b0000, 4'b0010);
        req = 4'b0000; tick();
        req = 4'b1000; tick();
`ifdef IRQ_NEST_EN
        expect_state("nest_preempt", 1'b1, 2'd3, 4'b1000, 4'b0010);
        ack = 1'b1; tick();
        expect_state("nest_ack_src3", 1'b0, 2'd0, 4'b0000, 4'b1010);
        eret = 1'b1; tick();
        expect_state("nest_eret_inner", 1'b0, 2'd0, 4'b0000, 4'b0010);
        eret = 1'b1; tick();
        expect_state("nest_eret_outer", 1'b0, 2'd0, 4'b0000, 4'b0000);
`else
        expect_state("nest_blocked", 1'b0, 2'd0, 4'b1000, 4'b0010);
        ack = 1'b1; tick();
        expect_state("nest_ack_blocked", 1'b0, 2'd0, 4'b1000, 4'b0010);
        eret = 1'b1; tick();
        expect_state("nest_eret_release", 1'b1, 2'd3, 4'b1000, 4'b0000);
        eret = 1'b1; tick();
        expect_state("eret_empty_ignored", 1'b1, 2'd3, 4'b1000, 4'b0000);
        ack = 1'b1; tick();
        expect_state("ack_src3_late", 1'b0, 2'd0, 4'b0000, 4'b1000);
        eret = 1'b1; tick();
        expect_state("eret_src3_late", 1'b0, 2'd0, 4'b0000, 4'b0000);
`endif

        req = 4'b0000; tick();
        req = 4'b0100; tick();
        expect_state("rise_src2_again", 1'b1, 2'd2, 4'b0100, 4'b0000);
        req = 4'b0000; tick();
        req = 4'b0100; ack = 1'b1; tick();
        expect_state("ack_and_edge_set_wins", 1'b0, 2'd0, 4'b0100, 4'b0100);

        req = 4'b1100; tick();
`ifdef IRQ_NEST_EN
        expect_state("preempt_src3", 1'b1, 2'd3, 4'b1100, 4'b0100);
        ack = 1'b1; eret = 1'b1; tick();
        expect_state("ack_eret_same_cycle", 1'b0, 2'd0, 4'b0100, 4'b1000);
`else
        expect_state("src3_waits", 1'b0, 2'd0, 4'b1100, 4'b0100);
        ack = 1'b1; eret = 1'b1; tick();
        expect_state("ack_eret_same_cycle", 1'b1, 2'd3, 4'b1100, 4'b0000);
`endif

        mask_we = 1'b1; mask = 4'b0000; tick();
        rst = 1'b1; tick();
        rst = 1'b0; tick();
        expect_state("reset_mid_handler", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        expect_state("mask_reset_src0", 1'b1, 2'd0, 4'b0001, 4'b0000);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
